// File: rtl/ntsc_tg_pkg.sv
// ============================================================================
// Module : ntsc_tg_pkg
// Brief  : Shared line-type enum, default 4fsc NTSC timing constants and the
//          vertical line classifier used by the timing generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ntsc_tg_pkg;

    typedef enum logic [1:0] {
        LT_EQ     = 2'd0,
        LT_BROAD  = 2'd1,
        LT_NORMAL = 2'd2
    } line_t;

    localparam int C_H_TOTAL    = 910;
    localparam int C_V_TOTAL    = 262;
    localparam int C_H_SYNC_W   = 67;
    localparam int C_H_EQ_W     = 33;
    localparam int C_H_SER_W    = 67;
    localparam int C_H_BST_S    = 76;
    localparam int C_H_BST_W    = 36;
    localparam int C_H_ACT_S    = 150;
    localparam int C_H_ACT_E    = 889;
    localparam int C_V_ACT_S    = 21;
    localparam int C_V_ACT_E    = 261;
    localparam int C_HALF_LINE  = 455;
    localparam int C_BURST_LINE = 9;

    // Lines 0-2 and 6-8 carry equalizing pulses, 3-5 carry broad (vsync) pulses.
    function automatic line_t line_type(input logic [8:0] vc);
        if (vc <= 9'd2 || (vc >= 9'd6 && vc <= 9'd8)) begin
            return LT_EQ;
        end else if (vc >= 9'd3 && vc <= 9'd5) begin
            return LT_BROAD;
        end
        return LT_NORMAL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ntsc_tg_if.sv
// ============================================================================
// Module : ntsc_tg_if
// Brief  : Control inputs and per-sample timing outputs of the NTSC generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ntsc_tg_if;
    logic       CK_EE_i;
    logic       EN_i;
    logic       XSYNC_o;
    logic       BLANK_o;
    logic       BURST_o;
    logic       XR_o;
    logic       DE_o;
    logic [9:0] X_o;
    logic [7:0] Y_o;
    logic [9:0] HCNT_o;
    logic [8:0] VCNT_o;
    logic       FRAME_o;

    modport master (
        input  CK_EE_i, EN_i,
        output XSYNC_o, BLANK_o, BURST_o, XR_o, DE_o, X_o, Y_o, HCNT_o, VCNT_o, FRAME_o
    );

    modport slave (
        output CK_EE_i, EN_i,
        input  XSYNC_o, BLANK_o, BURST_o, XR_o, DE_o, X_o, Y_o, HCNT_o, VCNT_o, FRAME_o
    );
endinterface

`default_nettype wire

// File: rtl/ntsc_tg_line_decode.sv
// ============================================================================
// Module : ntsc_tg_line_decode
// Brief  : Combinational decode of (hc, vc) into sync/blank/burst/de flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ntsc_tg_line_decode
    import ntsc_tg_pkg::*;
#(
    parameter int H_TOTAL  = C_H_TOTAL,
    parameter int V_TOTAL  = C_V_TOTAL,
    parameter int H_SYNC_W = C_H_SYNC_W,
    parameter int H_EQ_W   = C_H_EQ_W,
    parameter int H_SER_W  = C_H_SER_W,
    parameter int H_BST_S  = C_H_BST_S,
    parameter int H_BST_W  = C_H_BST_W,
    parameter int H_ACT_S  = C_H_ACT_S,
    parameter int H_ACT_E  = C_H_ACT_E,
    parameter int V_ACT_S  = C_V_ACT_S,
    parameter int V_ACT_E  = C_V_ACT_E
) (
    input  wire logic [9:0] i_hc,
    input  wire logic [8:0] i_vc,
    output logic            o_xsync,
    output logic            o_blank,
    output logic            o_burst,
    output logic            o_de
);

    int    w_h;
    int    w_v;
    line_t w_lt;
    logic  w_vblank;

    assign w_h  = {22'd0, i_hc};
    assign w_v  = {23'd0, i_vc};
    assign w_lt = line_type(i_vc);

    always_comb begin
        o_xsync = 1'b1;
        case (w_lt)
            LT_EQ:    o_xsync = !((w_h < H_EQ_W) ||
                                  (w_h >= C_HALF_LINE && w_h < C_HALF_LINE + H_EQ_W));
            LT_BROAD: o_xsync = (w_h >= C_HALF_LINE - H_SER_W && w_h < C_HALF_LINE) ||
                                (w_h >= H_TOTAL - H_SER_W);
            default:  o_xsync = (w_h >= H_SYNC_W);
        endcase
    end

    assign w_vblank = (w_v < V_ACT_S) || (w_v >= V_ACT_E);
    assign o_blank  = w_vblank || (w_h < H_ACT_S) || (w_h >= H_ACT_E);
    // Last line of the frame precedes the equalizing group, so it carries no burst.
    assign o_burst  = (w_lt == LT_NORMAL) && (w_v >= C_BURST_LINE) && (w_v != V_TOTAL - 1) &&
                      (w_h >= H_BST_S) && (w_h < H_BST_S + H_BST_W);
    assign o_de     = !o_blank;

endmodule

`default_nettype wire

// File: rtl/ntsc_tg.sv
// ============================================================================
// Module : ntsc_tg
// Brief  : 4fsc NTSC timing generator: sample/line counters with registered
//          sync, blank, burst, XR and active-area coordinate outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ntsc_tg
    import ntsc_tg_pkg::*;
#(
    parameter int H_TOTAL  = C_H_TOTAL,
    parameter int V_TOTAL  = C_V_TOTAL,
    parameter int H_SYNC_W = C_H_SYNC_W,
    parameter int H_EQ_W   = C_H_EQ_W,
    parameter int H_SER_W  = C_H_SER_W,
    parameter int H_BST_S  = C_H_BST_S,
    parameter int H_BST_W  = C_H_BST_W,
    parameter int H_ACT_S  = C_H_ACT_S,
    parameter int H_ACT_E  = C_H_ACT_E,
    parameter int V_ACT_S  = C_V_ACT_S,
    parameter int V_ACT_E  = C_V_ACT_E
) (
    input  wire logic  CK_i,
    input  wire logic  XAR_i,
    ntsc_tg_if.master  tg
);

    if (!(H_SYNC_W < H_BST_S)) begin : g_chk_sync
        $error("ntsc_tg: H_SYNC_W must be below H_BST_S");
    end
    if (!(H_BST_S + H_BST_W <= H_ACT_S)) begin : g_chk_burst
        $error("ntsc_tg: burst must end before H_ACT_S");
    end
    if (!(H_ACT_E <= H_TOTAL)) begin : g_chk_act
        $error("ntsc_tg: H_ACT_E must not exceed H_TOTAL");
    end
    if (!(V_ACT_S >= 9)) begin : g_chk_vact
        $error("ntsc_tg: V_ACT_S must be at least 9");
    end

    logic [9:0] r_hc;
    logic [8:0] r_vc;
    logic       r_started;
    logic       r_xsync, r_blank, r_burst, r_xr, r_de, r_frame;
    logic [9:0] r_x, r_hcnt;
    logic [7:0] r_y;
    logic [8:0] r_vcnt;

    logic w_xsync, w_blank, w_burst, w_de;
    logic w_origin, w_h_last, w_v_last;

    ntsc_tg_line_decode #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_SYNC_W(H_SYNC_W), .H_EQ_W(H_EQ_W),
        .H_SER_W(H_SER_W), .H_BST_S(H_BST_S), .H_BST_W(H_BST_W), .H_ACT_S(H_ACT_S),
        .H_ACT_E(H_ACT_E), .V_ACT_S(V_ACT_S), .V_ACT_E(V_ACT_E)
    ) u_decode (
        .i_hc   (r_hc),
        .i_vc   (r_vc),
        .o_xsync(w_xsync),
        .o_blank(w_blank),
        .o_burst(w_burst),
        .o_de   (w_de)
    );

    assign w_origin = (r_hc == 10'd0) && (r_vc == 9'd0);
    assign w_h_last = (r_hc == 10'(H_TOTAL - 1));
    assign w_v_last = (r_vc == 9'(V_TOTAL - 1));

    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            r_hc      <= '0;
            r_vc      <= '0;
            r_started <= 1'b0;
            r_xsync   <= 1'b1;
            r_blank   <= 1'b1;
            r_burst   <= 1'b0;
            r_xr      <= 1'b0;
            r_de      <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_frame   <= 1'b0;
        end else if (tg.CK_EE_i) begin
            if (!tg.EN_i) begin
                r_hc      <= '0;
                r_vc      <= '0;
                r_started <= 1'b0;
                r_xsync   <= 1'b1;
                r_blank   <= 1'b1;
                r_burst   <= 1'b0;
                r_xr      <= 1'b0;
                r_de      <= 1'b0;
                r_x       <= '0;
                r_y       <= '0;
                r_hcnt    <= '0;
                r_vcnt    <= '0;
                r_frame   <= 1'b0;
            end else begin
                r_xsync   <= w_xsync;
                r_blank   <= w_blank;
                r_burst   <= w_burst;
                r_de      <= w_de;
                // XR rises on the very sample that reports the frame origin.
                r_xr      <= r_started | w_origin;
                r_started <= r_started | w_origin;
                r_x       <= w_de ? (r_hc - 10'(H_ACT_S)) : '0;
                r_y       <= w_de ? 8'(r_vc - 9'(V_ACT_S)) : '0;
                r_hcnt    <= r_hc;
                r_vcnt    <= r_vc;
                r_frame   <= w_origin;
                if (w_h_last) begin
                    r_hc <= '0;
                    r_vc <= w_v_last ? '0 : r_vc + 9'd1;
                end else begin
                    r_hc <= r_hc + 10'd1;
                end
            end
        end
    end

    assign tg.XSYNC_o = r_xsync;
    assign tg.BLANK_o = r_blank;
    assign tg.BURST_o = r_burst;
    assign tg.XR_o    = r_xr;
    assign tg.DE_o    = r_de;
    assign tg.X_o     = r_x;
    assign tg.Y_o     = r_y;
    assign tg.HCNT_o  = r_hcnt;
    assign tg.VCNT_o  = r_vcnt;
    assign tg.FRAME_o = r_frame;

endmodule

`default_nettype wire
